tick_gen_bank: RTL and testbench
================================

# tick_gen_bank

Parametrised bank of NCH independent clock-enable generators for the game's timing (fall rate, digit scan, 1 Hz timer, display refresh). Each channel produces a one-cycle `tick` strobe and a 50 % `sq` square wave from a runtime-programmable divisor. Consumers stay on `clk` and use `tick` as an enable, so no divided clocks are generated. Divisor changes are glitch-free, and all channels can be phase-aligned with `sync`.

## Interface
- `NCH`, 4: number of channels (1..16).
- `CW`, 32: counter/divisor width.
- `DEF_DIV`, {32'd4000000, 32'd200000, 32'd50000000, 32'd131072}: packed NCH*CW reset divisors; channel i uses bits [i*CW +: CW].
- `SW`, $clog2(NCH) (min 1): width of the channel select.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  NCH: per-channel count enable.
- `sync`  in  1: restart all channels in phase.
- `div_wr`  in  1: divisor write strobe.
- `div_sel`  in  SW: target channel for the write.
- `div_data`  in  CW: new divisor.
- `tick`  out  NCH: one-cycle strobe per period, registered.
- `sq`  out  NCH: square wave toggling on each tick, registered.
- `wr_err`  out  1: one-cycle pulse on a write with `div_sel` >= NCH, registered.

## Operation
- Per channel: `shadow` divisor, `active` divisor, counter `cnt` (all CW bits).
- Write: when `div_wr` is high and `div_sel` < NCH, `shadow[div_sel]` <= `div_data` at the edge. When `div_sel` >= NCH, no state changes and `wr_err` = 1 for the next cycle.
- Count rule at each edge, per channel i, evaluated in priority order:
  - `sync`: `cnt`=0, `tick`=0, `sq`=0, `active`=`shadow`. This overrides `en`.
  - `active`==0 (channel idle): `cnt`=0, `tick`=0, `sq` holds, and `active` reloads from `shadow` on every edge.
  - `en[i]`==0: `cnt` and `sq` hold, `tick`=0.
  - `cnt`==`active`-1 (wrap): `cnt`=0, `tick`=1, `sq` toggles, `active`=`shadow`.
  - Otherwise: `cnt`=`cnt`+1, `tick`=0.
- Write bypass: any reload of `active` in the same edge as a valid write to that channel takes `div_data`, not the old `shadow`.
- The divisor change therefore takes effect at the next wrap, so the current period is never truncated. A `sync` applies it immediately.
- `active`=1: `tick` high on every enabled cycle; `sq` toggles every enabled cycle.
- Arithmetic: unsigned CW bits. `cnt` < `active` always holds, so no overflow. The maximum divisor is 2^CW-1.
- Enabled-cycle counting: `tick` period = D enabled cycles; `sq` period = 2D enabled cycles.

## Timing
- Reset values: `tick`=0, `sq`=0, `wr_err`=0, `cnt`=0, `shadow`=`active`=DEF_DIV slice.
- After reset release with `en` high and divisor D: the first `tick` is high in the cycle after the D-th rising edge. Subsequent ticks follow every D cycles.
- `tick` is exactly 1 cycle wide for D>=2, and continuously high for D=1.
- Write-to-effect latency: the write lands in `shadow` at edge N. `active` updates at the first wrap or `sync` at or after edge N, or at edge N itself if the channel is idle.
- `sync` and write in the same cycle: the channel restarts with the newly written divisor.
- `rst` asserted mid-period: outputs clear immediately and asynchronously, and any programmed divisors revert to DEF_DIV.
- No combinational path from inputs to outputs.

## Test plan
- NCH=3, DEF_DIV={5,3,1}, `en`=3'b111, run 30 cycles -> ch0 `tick` every cycle with `sq` toggling each cycle; ch1 `tick` every 3 cycles with `sq` period 6; ch2 `tick` every 5 cycles with `sq` period 10; first ch2 tick after edge 5.
- Ch2 running D=5; write 2 to ch2 at `cnt`=1 -> the remaining ticks of the current period stay 5 apart, then ticks are 2 apart with no short or double tick.
- Write 0 to ch1 -> after its next wrap there is no `tick` and `sq` freezes. Then write 4 -> the first tick occurs 4 cycles after the write edge.
- `en[2]` low for 7 cycles mid-period -> `cnt`/`sq` hold and no tick; the period resumes and completes after exactly 5 enabled cycles in total.
- `sync` pulse with a write of 6 to ch0 in the same cycle -> all `cnt`=0 and `sq`=0; ch0 ticks first 6 cycles later; ch1/ch2 ticks realign to the sync edge.
- Write with `div_sel`=3 (NCH=3) -> `wr_err` high for 1 cycle and divisors unchanged. Assert `rst` mid-period -> all outputs 0 immediately and divisors back to {5,3,1}.

Source files
------------

// File: rtl/tick_gen_bank.sv
// rtl/tick_gen_bank.sv - bank of programmable clock-enable tick and square-wave generators
module tick_gen_bank #(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter logic [NCH*CW-1:0] DEF_DIV = {32'd4000000, 32'd200000, 32'd50000000, 32'd131072},
    parameter int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           div_wr,
    input  logic [SW-1:0]  div_sel,
    input  logic [CW-1:0]  div_data,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic           wr_err
);

    localparam logic [CW-1:0] ONE = 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= div_wr && (int'(div_sel) >= NCH);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] shadow_q;
        logic [CW-1:0] active_q;
        logic [CW-1:0] cnt_q;
        logic          tick_q;
        logic          sq_q;
        logic          wr_hit;
        logic [CW-1:0] reload;

        assign wr_hit = div_wr && (int'(div_sel) == i);
        // A write landing on the same edge as a reload must win over the stale shadow.
        assign reload = wr_hit ? div_data : shadow_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= DEF_DIV[i*CW +: CW];
                active_q <= DEF_DIV[i*CW +: CW];
                cnt_q    <= '0;
                tick_q   <= 1'b0;
                sq_q     <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (wr_hit) begin
                    shadow_q <= div_data;
                end
                if (sync) begin
                    cnt_q    <= '0;
                    sq_q     <= 1'b0;
                    active_q <= reload;
                end else if (active_q == '0) begin
                    cnt_q    <= '0;
                    active_q <= reload;
                end else if (en[i]) begin
                    if (cnt_q == active_q - ONE) begin
                        cnt_q    <= '0;
                        tick_q   <= 1'b1;
                        sq_q     <= ~sq_q;
                        active_q <= reload;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            end
        end

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_gen_bank.sv
// tb/tb_tick_gen_bank.sv - scoreboard bench for tick_gen_bank against a countdown reference model
module tb_tick_gen_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  en = '0;
    logic        sync = 1'b0;
    logic        div_wr = 1'b0;
    logic [1:0]  div_sel = '0;
    logic [31:0] div_data = '0;
    logic [2:0]  tick;
    logic [2:0]  sq;
    logic        wr_err;

    tick_gen_bank #(
        .NCH(3),
        .CW(32),
        .DEF_DIV({32'd5, 32'd3, 32'd1}),
        .SW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync(sync),
        .div_wr(div_wr),
        .div_sel(div_sel),
        .div_data(div_data),
        .tick(tick),
        .sq(sq),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] tick;
        logic [2:0] sq;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each channel counts down the enabled cycles left until its next tick.
    logic [31:0] cur [3];
    logic [31:0] pend[3];
    logic [31:0] rem [3];
    logic [2:0]  sq_m;

    task automatic model_reset();
        logic [31:0] defs [3];
        defs[0] = 32'd1; defs[1] = 32'd3; defs[2] = 32'd5;
        for (int i = 0; i < 3; i++) begin
            cur[i]  = defs[i];
            pend[i] = defs[i];
            rem[i]  = defs[i];
        end
        sq_m = '0;
    endtask

    task automatic step(input logic [2:0] e, input logic s, input logic w,
                        input logic [1:0] sel, input logic [31:0] d);
        exp_t x;
        en = e; sync = s; div_wr = w; div_sel = sel; div_data = d;
        x.tick = '0;
        for (int i = 0; i < 3; i++) begin
            if (w && sel == i[1:0]) pend[i] = d;
            if (s) begin
                cur[i] = pend[i]; rem[i] = cur[i]; sq_m[i] = 1'b0;
            end else if (cur[i] == 0) begin
                cur[i] = pend[i]; rem[i] = cur[i];
            end else if (e[i]) begin
                if (rem[i] == 1) begin
                    x.tick[i] = 1'b1; sq_m[i] = ~sq_m[i];
                    cur[i] = pend[i]; rem[i] = cur[i];
                end else begin
                    rem[i] = rem[i] - 1;
                end
            end
        end
        x.sq  = sq_m;
        x.err = w && (sel >= 2'd3);
        x.cyc = cyc + 1;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(3'b111, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (tick !== 3'b000 || sq !== 3'b000 || wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: tick=%b sq=%b wr_err=%b, required all zero", name, tick, sq, wr_err);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            vectors++;
            if (tick !== x.tick || sq !== x.sq || wr_err !== x.err) begin
                miscompares++;
                $display("FAIL edge%0d: tick=%b sq=%b wr_err=%b, required tick=%b sq=%b wr_err=%b",
                         x.cyc, tick, sq, wr_err, x.tick, x.sq, x.err);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        check_zero("after_release");

        run(30);
        step(3'b111, 1'b0, 1'b1, 2'd2, 32'd2);
        run(15);
        step(3'b111, 1'b0, 1'b1, 2'd1, 32'd0);
        run(8);
        step(3'b111, 1'b0, 1'b1, 2'd1, 32'd4);
        run(10);
        step(3'b111, 1'b0, 1'b1, 2'd2, 32'd5);
        run(7);
        for (int k = 0; k < 7; k++) step(3'b011, 1'b0, 1'b0, 2'd0, 32'd0);
        run(10);
        step(3'b111, 1'b1, 1'b1, 2'd0, 32'd6);
        run(15);
        step(3'b111, 1'b0, 1'b1, 2'd3, 32'd9);
        run(3);

        // Asynchronous reset landing mid-period, away from any clock edge.
        @(negedge clk);
        #1;
        div_wr = 1'b0; sync = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset_held");
        rst = 1'b0;
        run(20);

        for (int k = 0; k < 400; k++) begin
            logic [2:0]  e;
            logic        s, w;
            logic [1:0]  sel;
            logic [31:0] d;
            e   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            s   = ($urandom_range(0, 40) == 0);
            w   = ($urandom_range(0, 6) == 0);
            sel = 2'($urandom);
            d   = 32'($urandom_range(0, 7));
            step(e, s, w, sel, d);
        end
        en = 3'b000; div_wr = 1'b0; sync = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
